// File: rtl/ser_add.sv
// ---------------------------------------------------------------------------
// ser_add -- iterative adder/subtractor.
//
// Works through two WIDTH-bit operands LSB-first, BITS_PER_CYCLE bits per
// clock, through a short ripple chain of full-adder cells. The carry between
// chunks is held in a register. A start/done handshake lets a controller
// issue one operation at a time and then read a result that stays put.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   start in   request a new operation (sampled only while idle)
//   sub   in   0 = a+b, 1 = a-b (captured with start)
//   a     in   operand A (captured with start)
//   b     in   operand B (captured with start)
//   busy  out  operation in progress
//   done  out  one-cycle pulse when sum/carry/ovf have just been updated
//   sum   out  result modulo 2^WIDTH, held between operations
//   carry out  carry out of the MSB; for subtraction 1 means no borrow
//   ovf   out  signed (two's-complement) overflow
// ---------------------------------------------------------------------------
module ser_add #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  // Guarded copy of the chunk size so that a bad parameter reports the
  // error below instead of dividing by zero while elaborating.
  localparam int K  = (BITS_PER_CYCLE < 1) ? 1 : BITS_PER_CYCLE;
  localparam int N  = WIDTH / K;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (WIDTH < 2) begin : g_badWidth
    $error("ser_add: WIDTH must be at least 2");
  end
  if (BITS_PER_CYCLE < 1 || (WIDTH % K) != 0) begin : g_badChunk
    $error("ser_add: BITS_PER_CYCLE must be >= 1 and divide WIDTH");
  end

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_part;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_carryOut;
  logic             r_ovf;
  logic             r_done;

  logic [K-1:0]     w_s;
  logic             w_cOut;
  logic             w_cMsbIn;
  logic [WIDTH-1:0] w_partNext;

  // Ripple chain across the low K bits of the operand shift registers.
  // The carry entering the top cell is kept aside: on the final chunk that
  // cell is bit WIDTH-1, and its carry-in XOR carry-out is signed overflow.
  always_comb begin : p_chain
    logic carryVar;
    carryVar = r_carry;
    w_s      = '0;
    w_cMsbIn = 1'b0;
    for (int i = 0; i < K; i++) begin
      w_s[i] = r_a[i] ^ r_b[i] ^ carryVar;
      if (i == K - 1) begin
        w_cMsbIn = carryVar;
      end
      carryVar = (r_a[i] & r_b[i]) | (carryVar & (r_a[i] ^ r_b[i]));
    end
    w_cOut = carryVar;
  end

  // New chunk enters at the MSB end; after N chunks the first one has
  // travelled down to bit 0, so the register holds the sum in order.
  assign w_partNext = (WIDTH'(w_s) << (WIDTH - K)) | (r_part >> K);

  // Control and datapath. Subtraction is a + ~b + 1, the +1 coming from the
  // initial carry. Result registers only move on the final chunk so the
  // previous answer stays readable while the next operation runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_part     <= '0;
      r_carry    <= 1'b0;
      r_sum      <= '0;
      r_carryOut <= 1'b0;
      r_ovf      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> K;
          r_b     <= r_b >> K;
          r_part  <= w_partNext;
          r_carry <= w_cOut;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_sum      <= w_partNext;
            r_carryOut <= w_cOut;
            r_ovf      <= w_cOut ^ w_cMsbIn;
            r_done     <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = r_done;
  assign sum   = r_sum;
  assign carry = r_carryOut;
  assign ovf   = r_ovf;

endmodule
